uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Sequences the byte stream from the UART receiver (8-bit data + 1-cycle en strobe) into framed
//  register-write commands. Frame = SYNC, ADDR, LEN, LEN payload bytes, CHK.
//  Payload is buffered and committed to the register bus only after the frame validates.
//  Sits between the UART receiver and the register/config bus; one frame in flight at a time.
// PARAMETERS
//  SYNC_BYTE  8'hA5  frame start marker
//  MAX_LEN    16     max payload bytes per frame (1..255); sizes the payload buffer
//  TIMEOUT    50000  idle clocks between bytes before frame abort (1..65535), 16-bit counter
// PORTS
//  clk        in   1  clock
//  rst_n      in   1  synchronous active-low reset
//  rx_data    in   8  received byte, valid only when rx_en=1
//  rx_en      in   1  one-cycle strobe per received byte
//  wr_valid   out  1  register write request
//  wr_ready   in   1  bus accepts write when wr_valid&wr_ready
//  wr_addr    out  8  write address = ADDR+i, mod 256
//  wr_data    out  8  payload byte i
//  frame_ok   out  1  one-cycle pulse after last write accepted
//  frame_err  out  1  one-cycle pulse on abort
//  err_code   out  2  01 TIMEOUT, 10 BADLEN, 11 BADCHK; held until next frame_err; 00 after reset
//  rx_drop    out  1  one-cycle pulse when an rx_en byte is discarded during S_DRAIN
//  busy       out  1  1 in every state except S_IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, counters/sum cleared; reset mid-frame or mid-drain discards
//   all buffered data, no frame_ok/frame_err is issued.
//  S_IDLE: rx_en & rx_data==SYNC_BYTE -> S_ADDR; other bytes ignored silently.
//  S_ADDR: rx_en -> latch base addr, sum=byte -> S_LEN.
//  S_LEN: rx_en -> LEN==0 or LEN>MAX_LEN: frame_err, code BADLEN, -> S_IDLE (that byte is NOT
//   re-examined as SYNC); else latch LEN, sum+=byte, idx=0 -> S_DATA.
//  S_DATA: each rx_en stores buf[idx], sum+=byte, idx++; after byte LEN -> S_CHK.
//  S_CHK: rx_en -> byte==sum[7:0] -> S_DRAIN, idx=0; else frame_err, code BADCHK, -> S_IDLE.
//  Sum is 8-bit, wrap-around mod 256, over ADDR, LEN and payload.
//  Timeout: counter clears on every rx_en and on entering S_ADDR; in S_ADDR/S_LEN/S_DATA/S_CHK,
//   counter reaching TIMEOUT with no rx_en -> frame_err, code TIMEOUT, -> S_IDLE.
//   An rx_en in the same cycle as the timeout hit wins (byte processed, no timeout).
//  S_DRAIN: wr_valid=1 from the cycle after CHK strobe (1-cycle latency); wr_addr=base+idx,
//   wr_data=buf[idx] stable while wr_valid&!wr_ready. On accept idx++; after accepting write
//   LEN-1, wr_valid drops next cycle, frame_ok pulses that cycle, -> S_IDLE.
//   Back-to-back accepts give one write per clock. No timeout in S_DRAIN.
//  rx_en during S_DRAIN: byte dropped, rx_drop pulses; it is never treated as SYNC.
//  frame_ok and frame_err never assert together; frame_err coincides with entry to S_IDLE.
// CONFIGURATION
//  FRAME_CHK_EN defined: frame includes CHK byte, validated as above.
//  FRAME_CHK_EN undefined: no CHK byte and no S_CHK state; after payload byte LEN the FSM goes
//   straight to S_DRAIN (wr_valid next cycle); BADCHK code is never produced.
// TESTING
//  1 Good frame A5 10 02 11 22 CHK=0x45, wr_ready=1 -> writes (10,11),(11,22), then frame_ok.
//  2 Bad CHK A5 10 02 11 22 44 -> frame_err, err_code=11, no wr_valid, busy=0.
//  3 LEN=0 and LEN=MAX_LEN+1 -> frame_err, err_code=10; next A5 frame accepted normally.
//  4 A5 10 then silence TIMEOUT clocks -> frame_err, err_code=01 exactly at TIMEOUT.
//  5 ADDR=FF LEN=2 -> wr_addr FF then 00; wr_ready low 5 cycles -> addr/data held.
//  6 Byte strobed during S_DRAIN -> rx_drop pulse, no state change; rst_n low mid-drain -> idle.
//  Run 1-5 with FRAME_CHK_EN both defined and undefined (checksum-free frames in the latter).

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: turns the UART byte stream (SYNC, ADDR, LEN, payload[, CHK]) into buffered
// register writes that are issued only once the whole frame has validated. Define FRAME_CHK_EN for the CHK byte.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_en,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       rx_drop,
    output logic       busy
);
    localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef FRAME_CHK_EN
        S_CHK,
`endif
        S_DRAIN
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_BADLEN  = 2'b10,
        ERR_BADCHK  = 2'b11
    } err_e;

    state_e      state_q, state_d;
    err_e        err_code_q, err_code_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] cnt_q, cnt_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_drop_q, rx_drop_d;
    logic        buf_we;
    logic        waiting;
    logic        timeout_hit;
    logic [7:0]  buf_q [MAX_LEN];

    // Counter advances only while a frame is mid-reception; the timeout fires on the idle
    // cycle that would take it to TIMEOUT, so a byte arriving on that same cycle still wins.
    assign waiting     = (state_q != S_IDLE) && (state_q != S_DRAIN);
    assign timeout_hit = waiting && !rx_en && (cnt_q == TO_LAST);

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        err_code_d  = err_code_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cnt_d       = (rx_en || !waiting) ? 16'd0 : cnt_q + 16'd1;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_drop_d   = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            S_IDLE: if (rx_en && rx_data == SYNC_BYTE) state_d = S_ADDR;
            S_ADDR: if (rx_en) begin
                base_d  = rx_data;
                sum_d   = rx_data;
                state_d = S_LEN;
            end
            S_LEN: if (rx_en) begin
                if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_BADLEN;
                    state_d     = S_IDLE;
                end else begin
                    len_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    idx_d   = 8'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: if (rx_en) begin
                buf_we = 1'b1;
                sum_d  = sum_q + rx_data;
                idx_d  = idx_q + 8'd1;
                if (idx_q == len_q - 8'd1) begin
`ifdef FRAME_CHK_EN
                    state_d = S_CHK;
`else
                    idx_d   = 8'd0;
                    state_d = S_DRAIN;
`endif
                end
            end
`ifdef FRAME_CHK_EN
            S_CHK: if (rx_en) begin
                if (rx_data == sum_q) begin
                    idx_d   = 8'd0;
                    state_d = S_DRAIN;
                end else begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_BADCHK;
                    state_d     = S_IDLE;
                end
            end
`endif
            S_DRAIN: begin
                // Bytes arriving while the buffer drains are discarded, never parsed as SYNC.
                rx_drop_d = rx_en;
                if (wr_ready) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        frame_ok_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            err_code_q  <= ERR_NONE;
            base_q      <= 8'd0;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            sum_q       <= 8'd0;
            cnt_q       <= 16'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_code_q  <= err_code_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            rx_drop_q   <= rx_drop_d;
        end
    end

    // NOTE: the payload buffer has no reset; it is only read in S_DRAIN after being fully written.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[idx_q[IDX_W-1:0]] <= rx_data;
    end

    assign wr_valid  = (state_q == S_DRAIN);
    assign wr_addr   = wr_valid ? base_q + idx_q : 8'd0;
    assign wr_data   = wr_valid ? buf_q[idx_q[IDX_W-1:0]] : 8'd0;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign rx_drop   = rx_drop_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frame-level stimulus pushes expected writes/outcomes,
// an independent negedge monitor pops and compares them. Works with or without FRAME_CHK_EN.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;
    localparam int         MAX_LEN = 16;
    localparam int         TIMEOUT = 40;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       rx_drop;
    logic       busy;

    uart_rx_frame_ctrl #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_en(rx_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .rx_drop(rx_drop), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum {EV_WR, EV_OK, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] addr;
        logic [7:0] data;
        logic [1:0] code;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         checks     = 0;
    int         failures   = 0;
    int         cyc        = 0;
    int         drops_exp  = 0;
    int         drops_seen = 0;
    logic [1:0] last_code  = 2'b00;
    bit         rdy_rand   = 1'b0;
    bit         rdy_fixed  = 1'b1;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_addr  = 8'd0;
    logic [7:0] prev_data  = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pop_ev(input ev_kind_e k, output ev_t e);
        e = '{EV_WR, 8'd0, 8'd0, 2'd0, -1};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got %s expected nothing (cycle %0d)", k.name(), cyc);
            return 1'b0;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            failures++;
            $display("FAIL event_order: got %s expected %s (cycle %0d)", k.name(), e.kind.name(), cyc);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: samples on the falling edge, away from the register updates.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (rx_drop) drops_seen++;
            if (prev_stall) begin
                check("hold_valid", wr_valid, 1);
                check("hold_addr", wr_addr, prev_addr);
                check("hold_data", wr_data, prev_data);
            end
            if (wr_valid && wr_ready && pop_ev(EV_WR, e)) begin
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
            if (frame_ok) begin
                check("ok_err_exclusive", frame_err, 0);
                if (pop_ev(EV_OK, e)) check("ok_valid_dropped", wr_valid, 0);
            end
            if (frame_err && pop_ev(EV_ERR, e)) begin
                check("err_code", err_code, e.code);
                check("err_busy", busy, 0);
                if (e.cyc >= 0) check("timeout_cycle", cyc, e.cyc);
            end
            prev_stall <= wr_valid && !wr_ready;
            prev_addr  <= wr_addr;
            prev_data  <= wr_data;
        end
    end

    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_en   = 1'b1;
        tick();
        rx_en   = 1'b0;
    endtask

    // Occasional idle gap of TIMEOUT-1 puts the byte exactly on the timeout cycle.
    task automatic send_gap(input logic [7:0] b);
        int r;
        r = $urandom_range(0, 9);
        if (r == 9) repeat (TIMEOUT - 1) tick();
        else if (r >= 7) repeat ($urandom_range(1, 3)) tick();
        send(b);
    endtask

    task automatic push_err(input logic [1:0] code, input int at_cyc);
        exp_q.push_back('{EV_ERR, 8'd0, 8'd0, code, at_cyc});
        last_code = code;
    endtask

    task automatic wait_idle(input bit inject);
        int n;
        n = 0;
        while (busy && n < 4000) begin
            if (inject && $urandom_range(0, 5) == 0) begin
                rx_data = ($urandom_range(0, 1) == 1) ? SYNC : 8'($urandom);
                rx_en   = 1'b1;
                drops_exp++;
            end
            tick();
            rx_en = 1'b0;
            n++;
        end
        check("drain_done", busy, 0);
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] pl[$],
                              input logic [7:0] chk_xor, input bit inject);
        logic [7:0] len;
        logic [7:0] sum;
        bit         bad;
        len = 8'(pl.size());
        sum = addr + len;
        foreach (pl[i]) sum = sum + pl[i];
`ifdef FRAME_CHK_EN
        bad = (chk_xor != 8'd0);
`else
        bad = 1'b0;
`endif
        if (bad) push_err(2'b11, -1);
        else begin
            foreach (pl[i]) exp_q.push_back('{EV_WR, addr + 8'(i), pl[i], 2'd0, -1});
            exp_q.push_back('{EV_OK, 8'd0, 8'd0, 2'd0, -1});
        end
        send_gap(SYNC);
        send_gap(addr);
        send_gap(len);
        foreach (pl[i]) send_gap(pl[i]);
`ifdef FRAME_CHK_EN
        send_gap(sum ^ chk_xor);
`endif
        if (bad) check("busy_after_badchk", busy, 0);
        else wait_idle(inject);
    endtask

    task automatic send_badlen(input logic [7:0] addr, input logic [7:0] len);
        send(SYNC);
        send(addr);
        push_err(2'b10, -1);
        send(len);
        check("busy_after_badlen", busy, 0);
    endtask

    // depth = bytes sent after SYNC before the line goes silent
    task automatic send_timeout(input logic [7:0] addr, input int depth);
        logic [7:0] len;
        len = 8'($urandom_range(1, MAX_LEN));
        send(SYNC);
        if (depth >= 1) send(addr);
        if (depth >= 2) send(len);
        for (int j = 0; j < depth - 2; j++) send(8'($urandom));
        push_err(2'b01, cyc + TIMEOUT);
        repeat (TIMEOUT + 3) tick();
        check("busy_after_timeout", busy, 0);
    endtask

    task automatic rand_payload(input int len, output logic [7:0] pl[$]);
        pl = {};
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] b;
        int         len;
        int         kind;
        int         max_depth;

        rst_n   = 1'b0;
        rx_en   = 1'b0;
        rx_data = 8'd0;
        repeat (3) tick();
        check("rst_wr_valid", wr_valid, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_rx_drop", rx_drop, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        tick();

        // Good frame A5 10 02 11 22 [45]
        send_frame(8'h10, '{8'h11, 8'h22}, 8'h00, 1'b0);
        // Same frame with CHK 0x44
        send_frame(8'h10, '{8'h11, 8'h22}, 8'h01, 1'b0);
        // LEN boundaries; LEN=A5 must not restart a frame
        send_badlen(8'h30, 8'd0);
        send_frame(8'h31, '{8'h01}, 8'h00, 1'b0);
        send_badlen(8'h40, 8'(MAX_LEN + 1));
        rand_payload(MAX_LEN, pl);
        send_frame(8'h41, pl, 8'h00, 1'b0);
        send_badlen(8'h50, SYNC);
        send_frame(8'h51, '{8'h77, 8'h88, 8'h99}, 8'h00, 1'b0);
        // Silence after ADDR
        send_timeout(8'h10, 1);
        check("err_code_hold", err_code, last_code);

        // ADDR wrap with a 5-cycle stall on the first write
        rdy_fixed = 1'b0;
        send(SYNC); send(8'hFF); send(8'd2); send(8'hC1); send(8'hC2);
        exp_q.push_back('{EV_WR, 8'hFF, 8'hC1, 2'd0, -1});
        exp_q.push_back('{EV_WR, 8'h00, 8'hC2, 2'd0, -1});
        exp_q.push_back('{EV_OK, 8'd0, 8'd0, 2'd0, -1});
`ifdef FRAME_CHK_EN
        send(8'hFF + 8'd2 + 8'hC1 + 8'hC2);
`endif
        repeat (5) tick();
        rdy_fixed = 1'b1;
        wait_idle(1'b0);

        // Drop during drain, then reset mid-drain
        rdy_fixed = 1'b0;
        send(SYNC); send(8'h20); send(8'd1); send(8'h5A);
`ifdef FRAME_CHK_EN
        send(8'h7B);
`endif
        repeat (2) tick();
        check("drain_valid", wr_valid, 1);
        check("drain_addr", wr_addr, 8'h20);
        check("drain_data", wr_data, 8'h5A);
        send(SYNC);
        drops_exp++;
        tick();
        check("drop_no_state_change", wr_addr, 8'h20);
        rst_n = 1'b0;
        tick();
        check("midrst_wr_valid", wr_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err_code", err_code, 0);
        check("midrst_frame_ok", frame_ok, 0);
        last_code = 2'b00;
        rst_n = 1'b1;
        rdy_fixed = 1'b1;
        tick();
        send_frame(8'h60, '{8'h12, 8'h34}, 8'h00, 1'b0);

        // Randomized frames with random bus backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            check("err_code_hold", err_code, last_code);
            kind = $urandom_range(0, 8);
            len  = ($urandom_range(0, 4) == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
            b    = ($urandom_range(0, 3) == 0) ? 8'hF0 + 8'($urandom_range(0, 15)) : 8'($urandom);
            if (kind <= 5) begin
                rand_payload(len, pl);
                send_frame(b, pl, (kind == 5) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b1);
            end else if (kind == 6) begin
                send_badlen(b, ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else if (kind == 7) begin
`ifdef FRAME_CHK_EN
                max_depth = len + 2;
`else
                max_depth = len + 1;
`endif
                max_depth = (max_depth > 2 + len) ? 2 + len : max_depth;
                send_timeout(b, $urandom_range(0, max_depth < 2 ? max_depth : 2));
            end else begin
                repeat ($urandom_range(1, 4)) begin
                    b = 8'($urandom);
                    if (b == SYNC) b = 8'h00;
                    send(b);
                end
            end
        end

        rdy_rand = 1'b0;
        repeat (10) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        check("drop_count", drops_seen, drops_exp);
        check("final_err_code", err_code, last_code);
        check("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
